// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller.
//   SEG_TABLE  : 16-entry hex-to-segment table (bit0 = A ... bit6 = G),
//                patterns are active-high before any polarity inversion.
//   SEG_BLANK  : all-segments-off pattern, active-high.
//   MAX_DIGITS : widest display the controller supports.
//   get_nibble : returns nibble <idx> of a packed value (nibble 0 = rightmost).
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry 15 is listed first so that SEG_TABLE[n] is the pattern for hex n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [3:0] get_nibble(
    input logic [4*MAX_DIGITS-1:0] vec,
    input logic [2:0]              idx
  );
    return vec[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg_hex_decoder
// Combinational hex nibble to seven-segment pattern (active-high, bit0 = A).
//   i_nibble : 4-bit hex digit
//   o_seg    : 7-bit segment pattern
// -----------------------------------------------------------------------------
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
// Time-multiplexed seven-segment driver with double-buffered display value.
// A new reading is captured by 'load' into a pending buffer and only moves to
// the displayed (active) buffer at a frame boundary, so the display never
// tears mid-scan.
//
// Parameters:
//   NUM_DIGITS  : scanned digits (1..8)
//   REFRESH_DIV : clock cycles each digit stays lit (>= 1)
//   ACTIVE_LOW  : 1 = seg/dp/an driven active-low, 0 = active-high
//
// Ports:
//   clock, reset       : system clock, asynchronous active-high reset
//   enable             : 1 runs the scan, 0 freezes it and blanks outputs
//   load               : strobe capturing value/dp_mask
//   value, dp_mask     : packed nibbles (nibble 0 rightmost), dp requests
//   seg, dp, an        : registered segment, decimal point, anode drives
//   frame_done         : one-cycle pulse after each completed scan
//
// Build option: define SEG_LZB_EN to enable leading-zero blanking.
// -----------------------------------------------------------------------------
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  // Inactive output levels after polarity is applied.
  localparam logic [6:0]            SEG_OFF = SEG_BLANK ^ {7{POL}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

  logic [DIV_W-1:0]        r_div_cnt;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_flag;
  logic                    r_frame_done;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_tick;
  logic                    w_boundary;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg_pat;
  logic [NUM_DIGITS-1:0]   w_an_onehot;
  logic [NUM_DIGITS-1:0]   w_blank_vec;
  logic                    w_digit_blank;

  assign w_tick     = enable && (r_div_cnt == DIV_LAST);
  assign w_boundary = w_tick && (r_digit_idx == IDX_LAST);

  // Divider and digit index freeze together while enable is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
    end else if (enable) begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) begin
        r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
      end
    end
  end

  // Double buffer. A load landing on the boundary bypasses pending so the
  // fresh value is shown in the very next frame rather than one frame later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_act_val   <= '0;
      r_act_dp    <= '0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_mask;
      end
      if (w_boundary && load) begin
        r_act_val   <= value;
        r_act_dp    <= dp_mask;
        r_pend_flag <= 1'b0;
      end else if (w_boundary && r_pend_flag) begin
        r_act_val   <= r_pend_val;
        r_act_dp    <= r_pend_dp;
        r_pend_flag <= 1'b0;
      end else if (load) begin
        r_pend_flag <= 1'b1;
      end
    end
  end

  assign w_nibble    = get_nibble((4*MAX_DIGITS)'(r_act_val), 3'(r_digit_idx));
  assign w_an_onehot = NUM_DIGITS'(1) << r_digit_idx;

  seg_hex_decoder u_hex_decoder (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_pat)
  );

`ifdef SEG_LZB_EN
  // A digit is a leading zero when it and everything above it is zero and
  // it carries no decimal point; digit 0 always stays lit.
  assign w_blank_vec[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
    assign w_blank_vec[gi] = (r_act_val[4*NUM_DIGITS-1:4*gi] == '0) && !r_act_dp[gi];
  end
`else
  assign w_blank_vec = '0;
`endif

  assign w_digit_blank = w_blank_vec[r_digit_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seg        <= SEG_OFF;
      r_dp         <= POL;
      r_an         <= AN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (!enable || w_digit_blank) begin
        r_seg <= SEG_OFF;
        r_dp  <= POL;
        r_an  <= AN_OFF;
      end else begin
        r_seg <= w_seg_pat ^ {7{POL}};
        r_dp  <= r_act_dp[r_digit_idx] ^ POL;
        r_an  <= w_an_onehot ^ AN_OFF;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_controller
// Directed bench: main instance (4 digits, 4-cycle slots, active-high) plus an
// active-low instance showing 16'h0042 (leading-zero blanking when
// SEG_LZB_EN is defined).
// -----------------------------------------------------------------------------
module tb_seg_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  logic        load_al;
  logic [15:0] value_al;
  logic [3:0]  dp_mask_al;
  logic [6:0]  seg_al;
  logic        dp_al;
  logic [3:0]  an_al;
  logic        frame_done_al;

  int n_checks = 0;
  int n_errors = 0;
  int p = 0;              // enabled clock edges since reset release
  logic chk_alt = 1'b0;

  logic [3:0] alt_an  [4];
  logic [6:0] alt_seg [4];

  always #5 clk = ~clk;

  seg_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut (
    .clock      (clk),
    .reset      (rst),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  seg_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) u_dut_al (
    .clock      (clk),
    .reset      (rst),
    .enable     (enable),
    .load       (load_al),
    .value      (value_al),
    .dp_mask    (dp_mask_al),
    .seg        (seg_al),
    .dp         (dp_al),
    .an         (an_al),
    .frame_done (frame_done_al)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s p=%0d: observed %0h expected %0h", tag, p, obs, exp);
    end
  endtask

  // One clock edge, then check both instances at the falling edge.
  // s0..s3 are the expected patterns for digits 0..3, dpm the expected dp bits.
  task automatic step(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3,
                      input logic [3:0] dpm);
    logic en;
    int d;
    logic [6:0] es;
    @(posedge clk);
    en = enable;
    if (en) p++;
    @(negedge clk);
    d = ((p - 1) / 4) % 4;
    case (d)
      0: es = s0;
      1: es = s1;
      2: es = s2;
      default: es = s3;
    endcase
    if (en) begin
      chk("an", 32'(an), 32'(4'b0001 << d));
      chk("seg", 32'(seg), 32'(es));
      chk("dp", 32'(dp), 32'(dpm[d]));
      chk("frame_done", 32'(frame_done), 32'(p % 16 == 0));
    end else begin
      chk("gap_an", 32'(an), 32'h0);
      chk("gap_seg", 32'(seg), 32'h0);
      chk("gap_dp", 32'(dp), 32'h0);
      chk("gap_frame_done", 32'(frame_done), 32'h0);
    end
    if (chk_alt) begin
      chk("al_an", 32'(an_al), 32'(alt_an[d]));
      chk("al_seg", 32'(seg_al), 32'(alt_seg[d]));
      chk("al_dp", 32'(dp_al), 32'h1);
    end
    $display("p=%0d en=%0b an=%b seg=%h dp=%b fd=%b | al an=%b seg=%h", p, en, an, seg, dp,
             frame_done, an_al, seg_al);
  endtask

  initial begin
`ifdef SEG_LZB_EN
    alt_an[0] = 4'b1110; alt_seg[0] = 7'h24;
    alt_an[1] = 4'b1101; alt_seg[1] = 7'h19;
    alt_an[2] = 4'b1111; alt_seg[2] = 7'h7F;
    alt_an[3] = 4'b1111; alt_seg[3] = 7'h7F;
`else
    alt_an[0] = 4'b1110; alt_seg[0] = 7'h24;
    alt_an[1] = 4'b1101; alt_seg[1] = 7'h19;
    alt_an[2] = 4'b1011; alt_seg[2] = 7'h40;
    alt_an[3] = 4'b0111; alt_seg[3] = 7'h40;
`endif
    rst = 1'b1; enable = 1'b1;
    load = 1'b0; value = 16'h0; dp_mask = 4'h0;
    load_al = 1'b0; value_al = 16'h0; dp_mask_al = 4'h0;
    repeat (3) @(negedge clk);

    // Reset state: blank on both polarities.
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_al_seg", 32'(seg_al), 32'h7F);
    chk("rst_al_dp", 32'(dp_al), 32'h1);
    chk("rst_al_an", 32'(an_al), 32'hF);
    rst = 1'b0;

    // Free-running scan of zeros; the active-low instance gets 0042.
    step(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    load_al = 1'b1; value_al = 16'h0042;
    step(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    load_al = 1'b0;
    repeat (14) step(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    chk_alt = 1'b1;
    repeat (16) step(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    chk_alt = 1'b0;

    // Mid-frame load: no change until the boundary at p=48.
    repeat (4) step(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    load = 1'b1; value = 16'h1234; dp_mask = 4'b0010;
    step(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    load = 1'b0;
    repeat (11) step(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    repeat (16) step(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0010);

    // Two loads in one frame: the last wins (including its dp mask).
    repeat (2) step(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0010);
    load = 1'b1; value = 16'hAAAA; dp_mask = 4'b1111;
    step(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0010);
    load = 1'b0;
    repeat (3) step(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0010);
    load = 1'b1; value = 16'h5555; dp_mask = 4'b0000;
    step(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0010);
    load = 1'b0;
    repeat (9) step(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0010);
    repeat (16) step(7'h6D, 7'h6D, 7'h6D, 7'h6D, 4'b0000);

    // Load on the boundary tick (p=112) commits straight to active.
    repeat (15) step(7'h6D, 7'h6D, 7'h6D, 7'h6D, 4'b0000);
    load = 1'b1; value = 16'h0789;
    step(7'h6D, 7'h6D, 7'h6D, 7'h6D, 4'b0000);
    load = 1'b0;
    chk("pend_flag", 32'(dut.r_pend_flag), 32'h0);
    repeat (16) step(7'h6F, 7'h7F, 7'h07, 7'h3F, 4'b0000);

    // Enable gap two cycles into digit 2; digit 2 then finishes its slot.
    repeat (10) step(7'h6F, 7'h7F, 7'h07, 7'h3F, 4'b0000);
    enable = 1'b0;
    repeat (10) step(7'h6F, 7'h7F, 7'h07, 7'h3F, 4'b0000);
    enable = 1'b1;
    repeat (22) step(7'h6F, 7'h7F, 7'h07, 7'h3F, 4'b0000);

    // Reset mid-frame with a pending load: immediate blank, pending lost.
    repeat (5) step(7'h6F, 7'h7F, 7'h07, 7'h3F, 4'b0000);
    load = 1'b1; value = 16'hFFFF;
    step(7'h6F, 7'h7F, 7'h07, 7'h3F, 4'b0000);
    load = 1'b0;
    step(7'h6F, 7'h7F, 7'h07, 7'h3F, 4'b0000);
    rst = 1'b1;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'h00);
    chk("mid_rst_an", 32'(an), 32'h0);
    chk("mid_rst_dp", 32'(dp), 32'h0);
    chk("mid_rst_al_an", 32'(an_al), 32'hF);
    chk("mid_rst_al_seg", 32'(seg_al), 32'h7F);
    @(negedge clk);
    rst = 1'b0;
    p = 0;
    repeat (32) step(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
